// File: rtl/freq_pkg.sv
// Shared constants, FSM encoding and a saturating-add helper for the
// frequency counter and its display side.
package freq_pkg;

    localparam int CLK_HZ          = 100_000_000;
    localparam int GATE_CYCLES_DEF = 100_000_000;
    localparam int MAX_COUNT_DEF   = 9999;
    localparam int FREQ_W          = 16;

    typedef enum logic {
        GATE  = 1'b0,
        LATCH = 1'b1
    } gate_state_e;

    // Adds a single-bit increment without ever passing lim.
    function automatic logic [FREQ_W-1:0] sat_add(
        input logic [FREQ_W-1:0] a,
        input logic              inc,
        input logic [FREQ_W-1:0] lim
    );
        logic [FREQ_W-1:0] sum;
        sum = a + FREQ_W'(inc);
        if (a >= lim) begin
            return lim;
        end
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a previous-value flop; emits a one-cycle
// pulse for every synchronized rising edge of IN.
module sync_edge_detect (
    input  logic CLK,
    input  logic reset,
    input  logic IN,
    output logic edge_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = IN;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // All stages reset high so a high IN at release is not seen as a rise.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign edge_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/gate_freq_counter.sv
// Gated frequency counter: counts synchronized rising edges of IN over a
// window of GATE_CYCLES clocks and publishes a saturated count per window.
module gate_freq_counter
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = freq_pkg::GATE_CYCLES_DEF,
    parameter int MAX_COUNT   = freq_pkg::MAX_COUNT_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              IN,
    output logic [15:0]       freq,
    output logic              freq_valid,
    output logic              overflow,
    output gate_state_e       dbg_state
);

    localparam int TW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0]     TIMER_LAST = TW'(GATE_CYCLES - 2);
    localparam logic [FREQ_W-1:0] MAX_C      = FREQ_W'(MAX_COUNT);

    logic edge_pulse;

    sync_edge_detect u_sync_edge (
        .CLK        (CLK),
        .reset      (reset),
        .IN         (IN),
        .edge_pulse (edge_pulse)
    );

    gate_state_e       state_q,    state_d;
    logic [TW-1:0]     timer_q,    timer_d;
    logic [FREQ_W-1:0] edge_cnt_q, edge_cnt_d;
    logic              sat_q,      sat_d;
    logic [FREQ_W-1:0] freq_q,     freq_d;
    logic              overflow_q, overflow_d;
    logic              valid_q,    valid_d;
    logic              at_max;

    assign at_max = (edge_cnt_q == MAX_C);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        freq_d     = freq_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        unique case (state_q)
            GATE: begin
                if (edge_pulse) begin
                    if (at_max) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + FREQ_W'(1);
                    end
                end
                if (timer_q == TIMER_LAST) begin
                    state_d = LATCH;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            LATCH: begin
                // An edge arriving in this cycle still belongs to the closing window.
                freq_d     = sat_add(edge_cnt_q, edge_pulse, MAX_C);
                overflow_d = sat_q | (at_max & edge_pulse);
                valid_d    = 1'b1;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                timer_d    = '0;
                state_d    = GATE;
            end
            default: begin
                state_d = GATE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= GATE;
            timer_q    <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            freq_q     <= freq_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    // Outputs are registered together, so freq_valid marks the first cycle
    // in which the new freq/overflow pair is visible.
    assign freq       = freq_q;
    assign overflow   = overflow_q;
    assign freq_valid = valid_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_gate_freq_counter.sv
// Bench for gate_freq_counter: drives IN on falling edges, checks outputs on
// falling edges against a window-level edge-count model.
module tb_gate_freq_counter;
    import freq_pkg::*;

    localparam int GC = 100;
    localparam int MC = 20;

    logic        CLK = 1'b0;
    logic        reset;
    logic        IN;
    logic [15:0] freq;
    logic        freq_valid;
    logic        overflow;
    gate_state_e dbg_state;

    int total = 0;
    int bad   = 0;

    gate_freq_counter #(.GATE_CYCLES(GC), .MAX_COUNT(MC)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .IN         (IN),
        .freq       (freq),
        .freq_valid (freq_valid),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
    );

    always #5 CLK = ~CLK;

    // Reference model: n = rising CLK edges since reset release. A rise first
    // sampled at edge m is counted at edge m+2, i.e. in window (m+1)/GC.
    // Window w is published at edge (w+1)*GC.
    int          n;
    bit          last_in;
    int          win_cnt[int];
    logic [15:0] m_freq;
    logic        m_ovf;
    logic        m_valid;

    always @(posedge CLK or posedge reset) begin
        if (reset) begin
            n       = 0;
            last_in = 1'b1;
            win_cnt.delete();
            m_freq  = '0;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
        end else begin
            int w;
            int c;
            n = n + 1;
            if (IN && !last_in) begin
                w = (n + 1) / GC;
                if (!win_cnt.exists(w)) win_cnt[w] = 0;
                win_cnt[w] = win_cnt[w] + 1;
            end
            last_in = IN;
            m_valid = 1'b0;
            if (n % GC == 0) begin
                w = n / GC - 1;
                c = win_cnt.exists(w) ? win_cnt[w] : 0;
                m_freq  = 16'((c > MC) ? MC : c);
                m_ovf   = (c > MC);
                m_valid = 1'b1;
            end
        end
    end

    task automatic do_reset(input logic in_val, input int cycles);
        @(negedge CLK);
        IN    = in_val;
        reset = 1'b1;
        repeat (cycles) @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        IN    = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            total++;
            if ({freq_valid, overflow, freq} !== 18'd0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d freq=%0d valid=%0b ovf=%0b want 0/0/0",
                         i, freq, freq_valid, overflow);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 150; i++) begin
            IN = 1'b0;
            @(negedge CLK);
            total++;
            if ({freq_valid, overflow, freq} !== {m_valid, m_ovf, m_freq}) begin
                bad++;
                $display("FAIL reset_idle n=%0d freq=%0d/%0d valid=%0b/%0b ovf=%0b/%0b",
                         n, freq, m_freq, freq_valid, m_valid, overflow, m_ovf);
            end
        end
    endtask

    task automatic test_square10();
        do_reset(1'b0, 3);
        for (int i = 0; i < 350; i++) begin
            IN = ((i % 10) < 5);
            @(negedge CLK);
            total++;
            if ({freq_valid, overflow, freq} !== {m_valid, m_ovf, m_freq}) begin
                bad++;
                $display("FAIL square10 n=%0d freq=%0d/%0d valid=%0b/%0b ovf=%0b/%0b",
                         n, freq, m_freq, freq_valid, m_valid, overflow, m_ovf);
            end
            if (freq_valid === 1'b1 && n >= 2 * GC) begin
                total++;
                if (freq !== 16'd10 || overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL square10_value n=%0d freq=%0d ovf=%0b want 10/0", n, freq, overflow);
                end
            end
        end
    endtask

    task automatic test_high_at_reset();
        do_reset(1'b1, 4);
        for (int i = 0; i < GC; i++) begin
            IN = 1'b1;
            @(negedge CLK);
            total++;
            if ({freq_valid, overflow, freq} !== {m_valid, m_ovf, m_freq}) begin
                bad++;
                $display("FAIL high_reset n=%0d freq=%0d/%0d valid=%0b/%0b ovf=%0b/%0b",
                         n, freq, m_freq, freq_valid, m_valid, overflow, m_ovf);
            end
        end
        total++;
        if (freq_valid !== 1'b1 || freq !== 16'd0) begin
            bad++;
            $display("FAIL high_reset_first freq=%0d valid=%0b want 0/1", freq, freq_valid);
        end
    endtask

    task automatic test_saturate();
        do_reset(1'b0, 2);
        for (int i = 0; i < 400; i++) begin
            IN = (i < 200) ? (i % 2 == 0) : (((i - 200) % 20) >= 10);
            @(negedge CLK);
            total++;
            if ({freq_valid, overflow, freq} !== {m_valid, m_ovf, m_freq}) begin
                bad++;
                $display("FAIL saturate n=%0d freq=%0d/%0d valid=%0b/%0b ovf=%0b/%0b",
                         n, freq, m_freq, freq_valid, m_valid, overflow, m_ovf);
            end
            if (i == 199) begin
                total++;
                if (freq !== 16'd20 || overflow !== 1'b1) begin
                    bad++;
                    $display("FAIL saturate_fast freq=%0d ovf=%0b want 20/1", freq, overflow);
                end
            end
        end
        total++;
        if (freq !== 16'd5 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL saturate_recover freq=%0d ovf=%0b want 5/0", freq, overflow);
        end
    endtask

    task automatic test_latch_edge();
        do_reset(1'b0, 2);
        for (int i = 0; i < 2 * GC; i++) begin
            IN = (i >= GC - 3);
            @(negedge CLK);
            total++;
            if ({freq_valid, overflow, freq} !== {m_valid, m_ovf, m_freq}) begin
                bad++;
                $display("FAIL latch_edge n=%0d freq=%0d/%0d valid=%0b/%0b ovf=%0b/%0b",
                         n, freq, m_freq, freq_valid, m_valid, overflow, m_ovf);
            end
            if (i == GC - 1 || i == 2 * GC - 1) begin
                total++;
                if (freq_valid !== 1'b1 || freq !== ((i == GC - 1) ? 16'd1 : 16'd0)) begin
                    bad++;
                    $display("FAIL latch_edge_window i=%0d freq=%0d valid=%0b want %0d/1",
                             i, freq, freq_valid, (i == GC - 1) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0, 2);
        for (int i = 0; i < GC + 50; i++) begin
            IN = ((i % 10) >= 5);
            @(negedge CLK);
            total++;
            if ({freq_valid, overflow, freq} !== {m_valid, m_ovf, m_freq}) begin
                bad++;
                $display("FAIL reset_mid_pre n=%0d freq=%0d/%0d valid=%0b/%0b ovf=%0b/%0b",
                         n, freq, m_freq, freq_valid, m_valid, overflow, m_ovf);
            end
        end
        reset = 1'b1;
        #1;
        total++;
        if ({freq_valid, overflow, freq} !== 18'd0) begin
            bad++;
            $display("FAIL reset_mid_async freq=%0d valid=%0b ovf=%0b want 0/0/0",
                     freq, freq_valid, overflow);
        end
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        for (int i = 0; i < GC + 5; i++) begin
            IN = ((i % 10) >= 5);
            @(negedge CLK);
            total++;
            if ({freq_valid, overflow, freq} !== {m_valid, m_ovf, m_freq}) begin
                bad++;
                $display("FAIL reset_mid_post n=%0d freq=%0d/%0d valid=%0b/%0b ovf=%0b/%0b",
                         n, freq, m_freq, freq_valid, m_valid, overflow, m_ovf);
            end
        end
    endtask

    task automatic test_random();
        int hi_pct;
        do_reset(1'b0, 2);
        for (int i = 0; i < 5 * GC; i++) begin
            hi_pct = (i < 2 * GC) ? 50 : 25;
            IN = ($urandom_range(99, 0) < hi_pct);
            @(negedge CLK);
            total++;
            if ({freq_valid, overflow, freq} !== {m_valid, m_ovf, m_freq}) begin
                bad++;
                $display("FAIL random n=%0d freq=%0d/%0d valid=%0b/%0b ovf=%0b/%0b",
                         n, freq, m_freq, freq_valid, m_valid, overflow, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_square10();
        test_high_at_reset();
        test_saturate();
        test_latch_edge();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_freq_counter.md
GATE_FREQ_COUNTER -- requirements
Module: gate_freq_counter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 100_000_000, giving the measurement window length in CLK cycles (1 s at 100 MHz).
REQ-002 SHALL have parameter MAX_COUNT, default 9999, giving the saturation ceiling so the count fits the 4-digit display.
REQ-003 SHALL have port CLK, input, 1 bit: the single 100 MHz clock; all flops rise on posedge CLK.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port IN, input, 1 bit: the asynchronous signal under measurement.
REQ-006 SHALL have port freq, output, 16 bits: rising-edge count of the last completed window, unsigned binary, held between windows.
REQ-007 SHALL have port freq_valid, output, 1 bit: a one-cycle pulse in the cycle freq updates.
REQ-008 SHALL have port overflow, output, 1 bit: high when the last completed window saturated; held with freq.

Function
REQ-009 SHALL pass IN through a two-flop synchronizer, then a previous-value flop; edge = sync_q & ~prev_q.
REQ-010 SHALL assert edge in the third CLK edge after the first CLK edge that samples IN high following a low sample: a 2-cycle synchronizer latency plus the detect stage.
REQ-011 SHALL count only rising edges; falling edges and IN levels have no effect.
REQ-012 SHALL implement a two-state FSM, GATE and LATCH; GATE SHALL last GATE_CYCLES-1 cycles and LATCH exactly 1 cycle, so each window is exactly GATE_CYCLES cycles.
REQ-013 SHALL use a gate timer that counts 0..GATE_CYCLES-2 in GATE; GATE->LATCH when the timer equals GATE_CYCLES-2; LATCH->GATE unconditionally, with the timer cleared.
REQ-014 SHALL increment edge_cnt on each edge in GATE, saturating at MAX_COUNT and never wrapping, and SHALL set a sticky sat flag on any edge arriving while edge_cnt==MAX_COUNT.
REQ-015 SHALL, in LATCH, load freq with min(edge_cnt + edge, MAX_COUNT), so an edge in the LATCH cycle belongs to the closing window.
REQ-016 SHALL, in LATCH, load overflow with (sat flag) OR (edge_cnt==MAX_COUNT and edge), and pulse freq_valid.
REQ-017 SHALL, in LATCH, clear edge_cnt and the sat flag to 0 for the next window; no edge SHALL be lost or double-counted across window boundaries.
REQ-018 SHALL keep freq and overflow constant except in LATCH; freq_valid SHALL be 0 in every GATE cycle.
REQ-019 SHALL take the maximum resolvable input frequency as CLK/2 synchronized edges (IN high and low each at least 1 CLK cycle); faster inputs are out of scope.

Reset
REQ-020 SHALL set, on reset assertion and independent of CLK: freq=0, freq_valid=0, overflow=0, edge_cnt=0, sat=0, timer=0, FSM=GATE.
REQ-021 SHALL reset both synchronizer flops and prev_q to 1, so IN high at reset release produces no spurious edge.
REQ-022 SHALL, on reset mid-window, discard the partial count; the first window after release starts on the first CLK edge with reset low.

Structure
REQ-023 SHALL place the FSM state encodings (GATE, LATCH) and the default CLK_HZ/GATE_CYCLES/MAX_COUNT constants in shared package freq_pkg, also used by the display side.
REQ-024 SHALL implement the synchronizer plus edge detector as sub-module sync_edge_detect (ports CLK, reset, IN, edge); the top level holds the FSM, gate timer, edge counter and output registers.

Verification (GATE_CYCLES=100, MAX_COUNT=20 unless stated)
REQ-025 SHALL check reset held for 5 cycles -> freq=0, freq_valid=0, overflow=0; no freq_valid before 100 cycles after release.
REQ-026 SHALL check IN square wave of period 10 cycles -> freq_valid pulses every 100 cycles; from the second window onward freq=10, overflow=0.
REQ-027 SHALL check IN held high across reset release, then constant -> first window freq=0.
REQ-028 SHALL check IN period 2 cycles (50 edges per window) -> freq=20, overflow=1; then IN period 20 cycles -> next full window freq=5, overflow=0.
REQ-029 SHALL check a single edge timed to land in the LATCH cycle -> counted in the closing window (freq=1), and the next window freq=0.
REQ-030 SHALL check reset asserted at cycle 50 of a window with 5 edges counted -> freq=0 immediately, with no freq_valid until 100 cycles after release.
